// File: rtl/pulse_scheduler_pkg.sv
// Shared types for the pulse scheduler: descriptor layout, field widths and
// the scheduler state encoding.
package pulse_scheduler_pkg;

    // Width of the descriptor delay field (countdown start value).
    localparam int PULSE_REG_TSTART_W = 8;
    // Width of the pulse memory address carried to the generator.
    localparam int PULSE_MEM_ADDR_W   = 10;

    // One entry of the core's pulse_descriptor stream.
    typedef struct packed {
        logic [PULSE_REG_TSTART_W-1:0] delay;
        logic [PULSE_MEM_ADDR_W-1:0]   pulse_mem_addr;
    } pulse_descriptor_t;

    // Scheduler state; plain constants keep the encoding visible to checkers.
    typedef logic [1:0] sched_state_t;
    localparam sched_state_t S_IDLE  = 2'd0;
    localparam sched_state_t S_LOAD  = 2'd1;
    localparam sched_state_t S_WAIT  = 2'd2;
    localparam sched_state_t S_ISSUE = 2'd3;

endpackage

// File: rtl/pulse_scheduler_desc_fifo.sv
// Synchronous descriptor FIFO with extra-bit pointers. A push is ignored when
// full and a pop is ignored when empty; there is no full-bypass path, so a
// push is refused on a full cycle even if a pop happens on the same edge.
// clear empties the FIFO on the next edge and suppresses any push that cycle.
module pulse_desc_fifo
    import pulse_scheduler_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clear,
    input  logic                     push,
    input  pulse_descriptor_t        push_data,
    input  logic                     pop,
    output pulse_descriptor_t        pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    pulse_descriptor_t mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count    = wr_ptr - rd_ptr;
    assign pop_data = mem[rd_ptr[AW-1:0]];
    assign do_push  = push && !full && !clear;
    assign do_pop   = pop && !empty && !clear;

    // Pointer update: clear wins, otherwise independent push and pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Storage write; entries need no reset because pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/pulse_scheduler.sv
// Timed-issue scheduler: queues pulse descriptors, counts down each delay
// while run is high, then offers the pulse address to the generator and
// stamps it with the free-running timeline.
//
// Handshakes (both sides): a transfer happens on the rising clk edge where
// valid && ready are both high. The scheduler holds gen_valid and gen_addr
// stable until that edge (only flush or reset can withdraw it); in_ready
// never depends on in_valid.
module pulse_scheduler
    import pulse_scheduler_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int DELAY_W = PULSE_REG_TSTART_W,
    parameter int ADDR_W  = PULSE_MEM_ADDR_W,
    parameter int TS_W    = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  pulse_descriptor_t       in_desc,
    input  logic                    run,
    input  logic                    flush,
    output logic                    gen_valid,
    input  logic                    gen_ready,
    output logic [ADDR_W-1:0]       gen_addr,
    output logic [TS_W-1:0]         gen_timestamp,
    output logic [$clog2(DEPTH):0]  q_count,
    output logic                    late_err,
    output logic                    idle,
    output sched_state_t            state
);

    localparam logic [DELAY_W-1:0] DELAY_ONE = 1;
    localparam logic [TS_W-1:0]    TS_ONE    = 1;

    sched_state_t       state_q;
    sched_state_t       state_d;
    logic [DELAY_W-1:0] countdown;
    logic [TS_W-1:0]    timeline;
    logic [ADDR_W-1:0]  addr_q;
    logic               issue_first;

    pulse_descriptor_t  head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_push;
    logic               fifo_pop;
    logic               wait_done;

    // Descriptor queue; flush doubles as its synchronous clear.
    pulse_desc_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (flush),
        .push      (fifo_push),
        .push_data (in_desc),
        .pop       (fifo_pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (q_count)
    );

    assign in_ready  = !fifo_full && !flush;
    assign fifo_push = in_valid && in_ready;
    // LOAD is only entered with a non-empty queue, so the head is valid here.
    assign fifo_pop  = (state_q == S_LOAD) && !flush;
    // Countdown has expired and the timeline is running: ISSUE next edge.
    assign wait_done = (state_q == S_WAIT) && run && (countdown == '0);

    assign gen_valid = (state_q == S_ISSUE);
    assign gen_addr  = addr_q;
    assign idle      = (state_q == S_IDLE) && fifo_empty;
    assign state     = state_q;

    // Next-state selection; flush overrides every transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (run && !fifo_empty) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wait_done) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // run=0 does not abort an issue; it only blocks the next LOAD.
                if (gen_ready) begin
                    state_d = (run && !fifo_empty) ? S_LOAD : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (flush) begin
            state_d = S_IDLE;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Countdown: loaded from the popped descriptor, frozen while run is low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            countdown <= '0;
        end else if (flush) begin
            countdown <= '0;
        end else if (state_q == S_LOAD) begin
            countdown <= head.delay;
        end else if ((state_q == S_WAIT) && run && (countdown != '0)) begin
            countdown <= countdown - DELAY_ONE;
        end
    end

    // Address latch: captured at LOAD so gen_addr stays stable through ISSUE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q <= '0;
        end else if (fifo_pop) begin
            addr_q <= head.pulse_mem_addr;
        end
    end

    // Free-running timeline; wraps modulo 2^TS_W, cleared by flush.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timeline <= '0;
        end else if (flush) begin
            timeline <= '0;
        end else if (run) begin
            timeline <= timeline + TS_ONE;
        end
    end

    // Timestamp: the timeline value held in the cycle that enters ISSUE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gen_timestamp <= '0;
        end else if (wait_done && !flush) begin
            gen_timestamp <= timeline;
        end
    end

    // Marks the first ISSUE cycle so lateness is judged only there.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            issue_first <= 1'b0;
        end else begin
            issue_first <= (state_d == S_ISSUE) && (state_q != S_ISSUE);
        end
    end

    // Sticky late flag: generator not ready on the scheduled cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            late_err <= 1'b0;
        end else if (flush) begin
            late_err <= 1'b0;
        end else if ((state_q == S_ISSUE) && issue_first && !gen_ready) begin
            late_err <= 1'b1;
        end
    end

endmodule

// File: doc/pulse_scheduler.md
Name: pulse_scheduler

Overview:
Timed-issue scheduler between the core's pulse_descriptor stream (via the async FIFO read side) and the pulse generator.
- Buffers descriptors in a small FIFO.
- Counts down each descriptor's delay field, then presents its pulse_mem_addr to the generator with a valid/ready handshake.
- Stamps each pulse with a free-running timeline value and flags late issues, where the generator was not ready at the scheduled cycle.

Parameters:
DEPTH, 8, descriptor FIFO entries; power of 2, ≥2
DELAY_W, `PULSE_REG_TSTART_W, width of delay field and countdown
ADDR_W, `PULSE_MEM_ADDR_W, width of pulse memory address
TS_W, 32, timeline/timestamp width

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
in_valid  in  1  descriptor offered
in_ready  out  1  scheduler accepts descriptor
in_desc  in  pulse_descriptor_t  {delay, pulse_mem_addr}
run  in  1  1 = timeline runs and scheduling proceeds
flush  in  1  synchronous abort: empty queue, return to IDLE
gen_valid  out  1  pulse issue request
gen_ready  in  1  generator accepts pulse
gen_addr  out  ADDR_W  pulse_mem_addr of issuing pulse
gen_timestamp  out  TS_W  timeline value on entry to ISSUE
q_count  out  $clog2(DEPTH)+1  FIFO occupancy
late_err  out  1  sticky: a pulse was not accepted on its first ISSUE cycle
idle  out  1  state==IDLE and FIFO empty

Behaviour:
- Reset (reset_n=0, async): FIFO empty, state IDLE, countdown 0, timeline 0, gen_valid=0, gen_addr=0, gen_timestamp=0, late_err=0, q_count=0, in_ready=1 after release, idle=1.
- Accept: push on the edge where in_valid&&in_ready.
  - in_ready = !full && !flush.
  - No bypass when full: a push is refused even if a pop occurs in the same cycle.
- Timeline: increments by 1 each cycle run=1, wraps 2^TS_W-1 → 0; cleared by flush.
- State machine (sched_state_t):
  - IDLE: if run && !empty → LOAD.
  - LOAD (1 cycle): pop head; countdown ← delay; addr latch ← pulse_mem_addr; → WAIT.
  - WAIT: if run=0, hold countdown; else if countdown≠0, decrement; else → ISSUE, latching gen_timestamp ← timeline.
  - ISSUE: gen_valid=1, gen_addr stable. On gen_ready:
    - → LOAD if !empty && run;
    - else → IDLE.
    - gen_valid stays high until handshake. run=0 does not abort ISSUE.
- Latency:
  - Descriptor with delay D accepted into an empty FIFO in IDLE with run=1: gen_valid rises exactly D+3 cycles after the accept edge.
  - Back-to-back with gen_ready=1: rising edges of gen_valid are spaced delay+3 cycles. The compiler subtracts the constant overhead of 3.
  - delay=0 is legal; WAIT lasts 1 cycle.
- Late: if gen_ready=0 in the first ISSUE cycle, late_err←1 (sticky). Cleared only by reset or flush.
  - Subsequent countdowns are relative to the actual handshake, not the ideal time.
- flush (priority over all else, one cycle):
  - FIFO pointers cleared; state→IDLE; gen_valid=0 next cycle; countdown 0; timeline 0; late_err 0.
  - An in-flight ISSUE is dropped without handshake.
  - A simultaneous in_valid is not accepted.
- Simultaneous push+pop (not full): both occur; q_count unchanged.
- Reset asserted mid-operation: all state returns to reset values immediately; no gen_valid glitch after release.
- Widths: countdown DELAY_W unsigned; timeline TS_W unsigned modulo.

Decomposition:
- Shared package (common/pulse_descriptor.vh): pulse_descriptor_t, `PULSE_REG_TSTART_W, `PULSE_MEM_ADDR_W, sched_state_t enum {IDLE, LOAD, WAIT, ISSUE}.
- Sub-module pulse_desc_fifo:
  - Synchronous FIFO of pulse_descriptor_t with DEPTH entries.
  - Extra-bit pointers, full/empty/count outputs.
  - Synchronous clear input driven by flush.
- The scheduler FSM, countdown, timeline and late logic live in pulse_scheduler.

Test Plan:
- Reset then run=1, gen_ready=1, push {delay=5, addr=0x12} → gen_valid rises 8 cycles after accept, gen_addr=0x12, gen_timestamp = timeline at that point, late_err=0.
- Push 3 descriptors, delays {0, 4, 10}, addrs {1, 2, 3}, gen_ready=1 → three issues in order, gen_valid rising edges spaced 7 and 13 cycles, q_count returns to 0, idle=1.
- Push DEPTH+1 descriptors with run=0 → in_ready=0 after 8 accepts, q_count=8, 9th held until run=1 frees a slot, no gen_valid while run=0.
- delay=2, gen_ready held 0 for 4 cycles in ISSUE → gen_valid held with stable gen_addr for 5 cycles, late_err=1 and stays 1 after handshake.
- Flush during WAIT with 3 queued → next cycle q_count=0, idle=1, late_err=0, gen_valid never asserts; timeline=0.
- Deassert run mid-WAIT (countdown=3) for 10 cycles → countdown frozen, timeline frozen; gen_valid rises 3+1 cycles after run returns high.
